// File: rtl/fifo_param_pkg.sv
// Shared definitions for the parametrised FIFO: error codes and default geometry.
// Latency: n/a (constants only).
// Backpressure: n/a.
package fifo_param_pkg;

   localparam logic [1:0] ERR_NONE = 2'b00;
   localparam logic [1:0] ERR_OVF  = 2'b01;
   localparam logic [1:0] ERR_UDF  = 2'b10;

   localparam int DEF_DATA_WIDTH = 10;
   localparam int DEF_ADDR_WIDTH = 3;

endpackage

// File: rtl/memoria_fifo.sv
// FIFO storage: DATA_WIDTH x 2**ADDR_WIDTH array, one write port, one read port.
// Latency: write lands on the clock edge; read is combinational from the address.
// Backpressure: none, the caller only writes accepted words.
module memoria_fifo #(
   parameter int DATA_WIDTH = 10,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   // No reset: stored contents survive a FIFO reset and are simply orphaned.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_param.sv
// Single-clock FIFO with occupancy count, threshold flags and sticky coded error.
// Latency: standard mode data one cycle after the read request; FWFT head word visible one cycle after write.
// Backpressure: writes when full are dropped (overflow) unless a read pops in the same cycle; reads on empty are dropped (underflow).
module fifo_param
   import fifo_param_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int FWFT       = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  write_enable,
   input  logic                  read_enable,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [ADDR_WIDTH:0]   umbral_alto,
   input  logic [ADDR_WIDTH:0]   umbral_bajo,
   input  logic                  clear_error,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  valid_out,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic                  error,
   output logic [1:0]            error_code,
   output logic [ADDR_WIDTH:0]   count,
   output logic [ADDR_WIDTH-1:0] wr_ptr,
   output logic [ADDR_WIDTH-1:0] rd_ptr
);

   localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};

   logic                  rd_acc;
   logic                  wr_acc;
   logic                  new_err;
   logic [1:0]            new_code;
   logic [DATA_WIDTH-1:0] mem_rdata;

   assign full         = (count == DEPTH_C);
   assign empty        = (count == '0);
   assign almost_full  = (umbral_alto != '0) && (count >= umbral_alto);
   assign almost_empty = (count <= umbral_bajo);

   // A pop in the same cycle frees a slot, so a write into a full FIFO still goes through.
   assign rd_acc = read_enable && !empty;
   assign wr_acc = write_enable && (!full || rd_acc);

   always_comb begin
      new_code = ERR_NONE;
      if (write_enable && !wr_acc)    new_code = ERR_OVF;
      else if (read_enable && empty)  new_code = ERR_UDF;
   end
   assign new_err = (new_code != ERR_NONE);

   memoria_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem (
      .clk     (clk),
      .wr_en   (wr_acc),
      .wr_addr (wr_ptr),
      .wr_data (data_in),
      .rd_addr (rd_ptr),
      .rd_data (mem_rdata)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
         if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
         if (wr_acc && !rd_acc)      count <= count + 1'b1;
         else if (rd_acc && !wr_acc) count <= count - 1'b1;
      end
   end

   // First cause sticks; a clear in the same cycle as a fresh error yields the fresh one.
   always_ff @(posedge clk) begin
      if (reset) begin
         error      <= 1'b0;
         error_code <= ERR_NONE;
      end else if (new_err && (!error || clear_error)) begin
         error      <= 1'b1;
         error_code <= new_code;
      end else if (clear_error) begin
         error      <= 1'b0;
         error_code <= ERR_NONE;
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         assign data_out  = mem_rdata;
         assign valid_out = !empty;
      end else begin : g_std
         logic [DATA_WIDTH-1:0] dout_q;
         logic                  vld_q;

         always_ff @(posedge clk) begin
            if (reset) begin
               dout_q <= '0;
               vld_q  <= 1'b0;
            end else begin
               vld_q <= rd_acc;
               if (rd_acc) dout_q <= mem_rdata;
            end
         end

         assign data_out  = dout_q;
         assign valid_out = vld_q;
      end
   endgenerate

endmodule

// File: tb/tb_fifo_param.sv
// Bench for fifo_param: standard and FWFT instances share stimulus and are checked
// every cycle against a queue-based model, plus literal expectations per scenario.
module tb_fifo_param;
   import fifo_param_pkg::*;

   localparam int DW = DEF_DATA_WIDTH;
   localparam int AW = DEF_ADDR_WIDTH;
   localparam int D  = 2**AW;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          write_enable = 1'b0;
   logic          read_enable = 1'b0;
   logic [DW-1:0] data_in = '0;
   logic [AW:0]   umbral_alto = 4'd6;
   logic [AW:0]   umbral_bajo = 4'd1;
   logic          clear_error = 1'b0;

   logic [DW-1:0] d0_data_out, d1_data_out;
   logic          d0_valid_out, d1_valid_out;
   logic          d0_full, d1_full, d0_empty, d1_empty;
   logic          d0_af, d1_af, d0_ae, d1_ae;
   logic          d0_error, d1_error;
   logic [1:0]    d0_code, d1_code;
   logic [AW:0]   d0_count, d1_count;
   logic [AW-1:0] d0_wr_ptr, d1_wr_ptr, d0_rd_ptr, d1_rd_ptr;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fifo_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(0)) dut0 (
      .clk(clk), .reset(reset), .write_enable(write_enable), .read_enable(read_enable),
      .data_in(data_in), .umbral_alto(umbral_alto), .umbral_bajo(umbral_bajo),
      .clear_error(clear_error), .data_out(d0_data_out), .valid_out(d0_valid_out),
      .full(d0_full), .empty(d0_empty), .almost_full(d0_af), .almost_empty(d0_ae),
      .error(d0_error), .error_code(d0_code), .count(d0_count),
      .wr_ptr(d0_wr_ptr), .rd_ptr(d0_rd_ptr)
   );

   fifo_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1)) dut1 (
      .clk(clk), .reset(reset), .write_enable(write_enable), .read_enable(read_enable),
      .data_in(data_in), .umbral_alto(umbral_alto), .umbral_bajo(umbral_bajo),
      .clear_error(clear_error), .data_out(d1_data_out), .valid_out(d1_valid_out),
      .full(d1_full), .empty(d1_empty), .almost_full(d1_af), .almost_empty(d1_ae),
      .error(d1_error), .error_code(d1_code), .count(d1_count),
      .wr_ptr(d1_wr_ptr), .rd_ptr(d1_rd_ptr)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: queue of stored words, sticky error, last popped word.
   logic [DW-1:0] q[$];
   bit            started = 0;
   bit            m_err = 0;
   int            m_code = 0;
   bit            m_vld = 0;
   logic [DW-1:0] m_dout = '0;
   int            m_wr = 0;
   int            m_rd = 0;

   always @(posedge clk) begin
      bit rd, wr;
      int code;
      if (reset) begin
         q.delete();
         started = 1;
         m_err = 0; m_code = 0; m_vld = 0; m_dout = '0; m_wr = 0; m_rd = 0;
      end else if (started) begin
         rd = read_enable && (q.size() != 0);
         wr = write_enable && (q.size() < D || rd);
         code = (write_enable && !wr) ? 1 : ((read_enable && q.size() == 0) ? 2 : 0);
         m_vld = rd;
         if (rd) begin
            m_dout = q.pop_front();
            m_rd = (m_rd + 1) % D;
         end
         if (wr) begin
            q.push_back(data_in);
            m_wr = (m_wr + 1) % D;
         end
         if (code != 0 && (!m_err || clear_error)) begin
            m_err = 1; m_code = code;
         end else if (clear_error) begin
            m_err = 0; m_code = 0;
         end
      end
   end

   always @(posedge clk) begin
      int n;
      #2;
      if (started) begin
         n = q.size();
         chk("count",        d0_count,  n);
         chk("count_fwft",   d1_count,  n);
         chk("full",         d0_full,   n == D);
         chk("empty",        d0_empty,  n == 0);
         chk("almost_full",  d0_af,     (umbral_alto != 0) && (n >= int'(umbral_alto)));
         chk("almost_empty", d0_ae,     n <= int'(umbral_bajo));
         chk("full_fwft",    d1_full,   n == D);
         chk("empty_fwft",   d1_empty,  n == 0);
         chk("error",        d0_error,  m_err);
         chk("error_code",   d0_code,   m_code);
         chk("error_fwft",   d1_error,  m_err);
         chk("wr_ptr",       d0_wr_ptr, m_wr);
         chk("rd_ptr",       d0_rd_ptr, m_rd);
         chk("rd_ptr_fwft",  d1_rd_ptr, m_rd);
         chk("valid_out",    d0_valid_out, m_vld);
         chk("data_out",     d0_data_out,  m_dout);
         chk("valid_fwft",   d1_valid_out, n != 0);
         if (n != 0) chk("data_fwft", d1_data_out, q[0]);
      end
   end

   // Drives one cycle from a negedge and returns at the following negedge.
   task automatic cyc(input logic we, input logic re, input logic [DW-1:0] d);
      write_enable = we;
      read_enable  = re;
      data_in      = d;
      @(negedge clk);
   endtask

   logic [DW-1:0] vec [8] = '{10'h091, 10'h04A, 10'h093, 10'h046,
                              10'h0B5, 10'h164, 10'h1E5, 10'h266};

   initial begin
      @(negedge clk);
      cyc(0, 0, '0);
      reset = 1'b0;
      chk("rst_count", d0_count, 0);
      chk("rst_empty", d0_empty, 1);
      chk("rst_full",  d0_full,  0);
      chk("rst_ae",    d0_ae,    1);
      chk("rst_valid", d0_valid_out, 0);
      chk("rst_dout",  d0_data_out, 0);

      // Fill with the reference vector
      for (int i = 0; i < 8; i++) begin
         cyc(1, 0, vec[i]);
         chk("fill_count", d0_count, i + 1);
         if (i == 1) chk("ae_drop_at2", d0_ae, 0);
         if (i == 4) chk("af_low_at5",  d0_af, 0);
         if (i == 5) chk("af_rise_at6", d0_af, 1);
      end
      chk("fill_full",  d0_full,  1);
      chk("fill_error", d0_error, 0);

      // Overflow attempt
      cyc(1, 0, 10'h3FF);
      cyc(0, 0, '0);
      chk("ovf_error",  d0_error, 1);
      chk("ovf_code",   d0_code,  2'b01);
      chk("ovf_count",  d0_count, 8);
      chk("ovf_wr_ptr", d0_wr_ptr, 0);

      // Drain back-to-back
      for (int i = 0; i < 8; i++) begin
         cyc(0, 1, '0);
         chk("drain_data",  d0_data_out, vec[i]);
         chk("drain_valid", d0_valid_out, 1);
      end
      cyc(0, 0, '0);
      chk("drain_valid_off", d0_valid_out, 0);
      chk("drain_empty",     d0_empty, 1);
      chk("drain_rd_ptr",    d0_rd_ptr, 0);

      // Underflow behind a latched overflow, then clear
      cyc(0, 1, '0);
      chk("udf_masked_code", d0_code, 2'b01);
      clear_error = 1'b1;
      cyc(0, 0, '0);
      clear_error = 1'b0;
      chk("clr_error", d0_error, 0);
      chk("clr_code",  d0_code,  2'b00);
      cyc(0, 1, '0);
      chk("udf_code",  d0_code,  2'b10);
      clear_error = 1'b1;
      cyc(0, 0, '0);
      clear_error = 1'b0;

      // Full with simultaneous push/pop, high threshold disabled
      umbral_alto = '0;
      for (int i = 0; i < 8; i++) cyc(1, 0, 10'h100 + DW'(i));
      chk("af_disabled", d0_af, 0);
      chk("refill_full", d0_full, 1);
      for (int i = 0; i < 3; i++) begin
         cyc(1, 1, 10'h200 + DW'(i));
         chk("rw_data",  d0_data_out, 10'h100 + DW'(i));
         chk("rw_count", d0_count, 8);
         chk("rw_error", d0_error, 0);
      end
      umbral_alto = 4'd6;

      // FWFT head word and reset mid-stream
      reset = 1'b1;
      cyc(0, 0, '0);
      reset = 1'b0;
      cyc(1, 0, 10'h155);
      write_enable = 1'b0;
      chk("fwft_data",  d1_data_out, 10'h155);
      chk("fwft_valid", d1_valid_out, 1);
      cyc(1, 0, 10'h0AA);
      cyc(1, 0, 10'h033);
      chk("pre_rst_count", d0_count, 3);
      reset = 1'b1;
      cyc(1, 1, 10'h3C3);
      reset = 1'b0;
      cyc(0, 0, '0);
      chk("midrst_count", d1_count, 0);
      chk("midrst_empty", d1_empty, 1);
      chk("midrst_valid_fwft", d1_valid_out, 0);
      chk("midrst_valid_std",  d0_valid_out, 0);

      repeat (3) cyc(0, 0, '0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
